// File: rtl/clock_timebase.sv
// rtl/clock_timebase.sv - 1 Hz prescaler, seconds/minutes counters and hour strobe; manual set buttons under CLOCK_SET_EN
module clock_timebase #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       en_i,
    input  logic       clr_i,
`ifdef CLOCK_SET_EN
    input  logic       set_min_i,
    input  logic       set_hr_i,
`endif
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic       tick_1hz_o,
    output logic       inc_hr_o
);

    localparam logic [PRESC_W-1:0] LP_PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]         LP_LAST      = 6'd59;

    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nx;
    logic [5:0]         r_sec;
    logic [5:0]         r_min;
    logic [5:0]         w_sec_nx;
    logic [5:0]         w_min_nx;
    logic               r_tick;
    logic               r_inc_hr;
    logic               w_tick_nx;
    logic               w_inc_hr_nx;
    logic               w_min_evt;
    logic               w_hr_evt;

`ifdef CLOCK_SET_EN
    logic [1:0] r_min_sync;
    logic [1:0] r_hr_sync;
    logic       r_min_prev;
    logic       r_hr_prev;

    // two-flop synchronizers plus the previous synchronized level for edge detection
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_min_sync <= 2'b00;
            r_hr_sync  <= 2'b00;
            r_min_prev <= 1'b0;
            r_hr_prev  <= 1'b0;
        end else begin
            r_min_sync <= {r_min_sync[0], set_min_i};
            r_hr_sync  <= {r_hr_sync[0], set_hr_i};
            r_min_prev <= r_min_sync[1];
            r_hr_prev  <= r_hr_sync[1];
        end
    end

    // one event per press: synchronized level high while it was low last cycle
    assign w_min_evt = r_min_sync[1] & ~r_min_prev;
    assign w_hr_evt  = r_hr_sync[1] & ~r_hr_prev;
`else
    assign w_min_evt = 1'b0;
    assign w_hr_evt  = 1'b0;
`endif

    // next state: clear wins, then manual events override natural counting
    always_comb begin
        w_presc_nx  = r_presc;
        w_sec_nx    = r_sec;
        w_min_nx    = r_min;
        w_tick_nx   = 1'b0;
        w_inc_hr_nx = 1'b0;
        if (clr_i) begin
            w_presc_nx = '0;
            w_sec_nx   = 6'd0;
            w_min_nx   = 6'd0;
        end else begin
            if (en_i) begin
                if (r_presc == LP_PRESC_MAX) begin
                    w_presc_nx = '0;
                    w_tick_nx  = 1'b1;
                    if (r_sec == LP_LAST) begin
                        w_sec_nx = 6'd0;
                        if (r_min == LP_LAST) begin
                            w_min_nx    = 6'd0;
                            w_inc_hr_nx = 1'b1;
                        end else begin
                            w_min_nx = r_min + 6'd1;
                        end
                    end else begin
                        w_sec_nx = r_sec + 6'd1;
                    end
                end else begin
                    w_presc_nx = r_presc + PRESC_W'(1);
                end
            end
            // manual minute advance discards whatever natural advance happened this edge
            if (w_min_evt) begin
                w_presc_nx  = '0;
                w_sec_nx    = 6'd0;
                w_min_nx    = (r_min == LP_LAST) ? 6'd0 : r_min + 6'd1;
                w_tick_nx   = 1'b0;
                w_inc_hr_nx = 1'b0;
            end
            // a coincident natural wrap and manual hour press still yield a single strobe
            if (w_hr_evt) begin
                w_inc_hr_nx = 1'b1;
            end
        end
    end

    // counter and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_presc  <= '0;
            r_sec    <= 6'd0;
            r_min    <= 6'd0;
            r_tick   <= 1'b0;
            r_inc_hr <= 1'b0;
        end else begin
            r_presc  <= w_presc_nx;
            r_sec    <= w_sec_nx;
            r_min    <= w_min_nx;
            r_tick   <= w_tick_nx;
            r_inc_hr <= w_inc_hr_nx;
        end
    end

    assign sec_o      = r_sec;
    assign min_o      = r_min;
    assign tick_1hz_o = r_tick;
    assign inc_hr_o   = r_inc_hr;

endmodule

// File: tb/tb_clock_timebase.sv
// tb/tb_clock_timebase.sv - scoreboard bench for clock_timebase with TICKS_PER_SEC=4
module tb_clock_timebase;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       en_i;
    logic       clr_i;
`ifdef CLOCK_SET_EN
    logic       set_min_i;
    logic       set_hr_i;
`endif
    logic [5:0] sec_o;
    logic [5:0] min_o;
    logic       tick_1hz_o;
    logic       inc_hr_o;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [5:0] sec;
        logic [5:0] min;
        logic       tick;
        logic       hr;
    } ev_t;

    ev_t q[$];

    clock_timebase #(.TICKS_PER_SEC(4)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_i       (en_i),
        .clr_i      (clr_i),
`ifdef CLOCK_SET_EN
        .set_min_i  (set_min_i),
        .set_hr_i   (set_hr_i),
`endif
        .sec_o      (sec_o),
        .min_o      (min_o),
        .tick_1hz_o (tick_1hz_o),
        .inc_hr_o   (inc_hr_o)
    );

    always #5 clk_i = ~clk_i;

    // edges since reset release
    always @(posedge clk_i) cyc <= rstn_i ? cyc + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int s, input int m, input logic t, input logic h);
        ev_t e;
        e.cyc = c; e.sec = 6'(s); e.min = 6'(m); e.tick = t; e.hr = h;
        q.push_back(e);
    endtask

    task automatic async_rst_chk(input string nm);
        #2 rstn_i = 1'b0;
        #1;
        chk({nm, "_sec"},  {26'd0, sec_o}, 0);
        chk({nm, "_min"},  {26'd0, min_o}, 0);
        chk({nm, "_tick"}, {31'd0, tick_1hz_o}, 0);
        chk({nm, "_hr"},   {31'd0, inc_hr_o}, 0);
        @(negedge clk_i);
    endtask

`ifdef CLOCK_SET_EN
    task automatic press_min();
        set_min_i = 1'b1;
        repeat (4) @(negedge clk_i);
        set_min_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask
`endif

    // monitor: every pulse on tick/hr must match the next expected event
    always @(negedge clk_i) begin
        if (rstn_i === 1'b1 && (tick_1hz_o === 1'b1 || inc_hr_o === 1'b1)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: cyc=%0d tick=%b hr=%b sec=%0d min=%0d, required no pulse",
                         cyc, tick_1hz_o, inc_hr_o, sec_o, min_o);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.sec !== sec_o || e.min !== min_o ||
                    e.tick !== tick_1hz_o || e.hr !== inc_hr_o) begin
                    n_bad++;
                    $display("FAIL pulse_event: got cyc=%0d sec=%0d min=%0d tick=%b hr=%b required cyc=%0d sec=%0d min=%0d tick=%b hr=%b",
                             cyc, sec_o, min_o, tick_1hz_o, inc_hr_o, e.cyc, e.sec, e.min, e.tick, e.hr);
                end
            end
        end
    end

    initial begin
        int e0;
        rstn_i = 1'b0;
        en_i   = 1'b0;
        clr_i  = 1'b0;
`ifdef CLOCK_SET_EN
        set_min_i = 1'b0;
        set_hr_i  = 1'b0;
`endif
        repeat (3) @(negedge clk_i);
        chk("reset_sec",  {26'd0, sec_o}, 0);
        chk("reset_min",  {26'd0, min_o}, 0);
        chk("reset_tick", {31'd0, tick_1hz_o}, 0);
        chk("reset_hr",   {31'd0, inc_hr_o}, 0);

        // free run for one hour of ticks
        for (int k = 1; k <= 3600; k++)
            push_ev(4 * k, k % 60, (k / 60) % 60, 1'b1, (k % 3600) == 0);
        en_i   = 1'b1;
        rstn_i = 1'b1;
        repeat (240) @(negedge clk_i);
        chk("run240_sec", {26'd0, sec_o}, 0);
        chk("run240_min", {26'd0, min_o}, 1);
        repeat (14400 - 240) @(negedge clk_i);
        chk("hour_wrap_hr",  {31'd0, inc_hr_o}, 1);
        chk("hour_wrap_min", {26'd0, min_o}, 0);
        @(negedge clk_i);
        chk("hour_wrap_hr_after", {31'd0, inc_hr_o}, 0);
        chk("drained_run", q.size(), 0);

        // enable pause and clear
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int k = 1; k <= 30; k++) push_ev(4 * k, k, 0, 1'b1, 1'b0);
        push_ev(134, 31, 0, 1'b1, 1'b0);
        repeat (122) @(negedge clk_i);
        chk("pause_sec_before", {26'd0, sec_o}, 30);
        en_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("pause_sec_held", {26'd0, sec_o}, 30);
        en_i = 1'b1;
        repeat (5) @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("clr_sec",  {26'd0, sec_o}, 0);
        chk("clr_min",  {26'd0, min_o}, 0);
        chk("clr_tick", {31'd0, tick_1hz_o}, 0);
        push_ev(142, 1, 0, 1'b1, 1'b0);
        repeat (5) @(negedge clk_i);
        chk("post_clr_sec", {26'd0, sec_o}, 1);
        async_rst_chk("async_rst_b");
        chk("drained_pause", q.size(), 0);

`ifdef CLOCK_SET_EN
        // manual minute presses with counting frozen
        en_i = 1'b0;
        rstn_i = 1'b1;
        for (int i = 0; i < 59; i++) press_min();
        chk("presses_min", {26'd0, min_o}, 59);
        set_min_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("set_latency_min", {26'd0, min_o}, 59);
        @(negedge clk_i);
        chk("set_wrap_min", {26'd0, min_o}, 0);
        chk("set_wrap_sec", {26'd0, sec_o}, 0);
        repeat (47) @(negedge clk_i);
        chk("set_held_min", {26'd0, min_o}, 0);
        set_min_i = 1'b0;
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < 58; i++) press_min();
        set_min_i = 1'b1;
        repeat (3) @(negedge clk_i);
        e0 = cyc;
        chk("set_min59", {26'd0, min_o}, 59);
        en_i = 1'b1;
        set_min_i = 1'b0;

        // manual hour press coinciding with the natural 59:59 wrap
        for (int k = 1; k <= 59; k++) push_ev(e0 + 4 * k, k, 59, 1'b1, 1'b0);
        push_ev(e0 + 240, 0, 0, 1'b1, 1'b1);
        repeat (237) @(negedge clk_i);
        set_hr_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("coincide_hr", {31'd0, inc_hr_o}, 1);
        @(negedge clk_i);
        chk("coincide_hr_after", {31'd0, inc_hr_o}, 0);
        set_hr_i = 1'b0;
        push_ev(e0 + 244, 1, 0, 1'b1, 1'b0);
        push_ev(e0 + 248, 2, 0, 1'b1, 1'b0);
        push_ev(e0 + 252, 3, 0, 1'b1, 1'b0);
        repeat (9) @(negedge clk_i);
        set_min_i = 1'b1;
        repeat (4) @(negedge clk_i);
        set_min_i = 1'b0;
        chk("press_run_min", {26'd0, min_o}, 1);
        chk("press_run_sec", {26'd0, sec_o}, 0);
        async_rst_chk("async_rst_c");
        chk("drained_set", q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
